// File: rtl/ay_bus_decode.sv
// AY-slot bus decoder: synchronises the asynchronous AY bus, qualifies each
// phase over QUAL_CYC stable samples and emits address/data/config strobes.
module ay_bus_decode #(
  parameter int unsigned QUAL_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       aybc1,
  input  logic       aybc2,
  input  logic       aybdir,
  input  logic       aya8,
  input  logic       aya9_n,
  input  logic [7:0] ayd_in,
  output logic       addr_stb,
  output logic       wr_stb,
  output logic       wr_port,
  output logic       rd_en,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic [3:0] cfg
);

  localparam int unsigned CW = (QUAL_CYC < 2) ? 1 : $clog2(QUAL_CYC + 1);
  localparam logic [CW-1:0] QMAX = CW'(QUAL_CYC);

  typedef enum logic [1:0] {M_INACT, M_READ, M_WRITE, M_LATCH} mode_t;
  typedef enum logic [2:0] {S_DISARM, S_IDLE, S_QUAL, S_LATCH, S_WRITE, S_READ} state_t;
  typedef enum logic [1:0] {A_NONE, A_ADDR, A_PORT, A_WR} act_t;

  // {aybdir, aybc1, aybc2, aya8, aya9_n}
  logic [4:0] ctl_m, ctl_s;
  logic [7:0] d_m, d_s;

  // Two-flop synchroniser with data pipeline kept in step; deliberately unreset.
  always_ff @(posedge clk) begin
    ctl_m <= {aybdir, aybc1, aybc2, aya8, aya9_n};
    ctl_s <= ctl_m;
    d_m   <= ayd_in;
    d_s   <= d_m;
  end

  logic  sel_c;
  mode_t mode_c;

  assign sel_c  = ctl_s[1] & ~ctl_s[0] & ctl_s[2];
  assign mode_c = sel_c ? mode_t'(ctl_s[4:3]) : M_INACT;

  state_t        state, state_nx;
  mode_t         cand, cand_nx;
  act_t          act, act_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [7:0]    shadow, shadow_nx;
  logic          exit_c;
  logic          addr_stb_nx, wr_stb_nx, wr_port_nx, rd_en_nx;
  logic [7:0]    reg_addr_nx, wr_data_nx;
  logic [3:0]    cfg_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_DISARM;
      cand     <= M_INACT;
      act      <= A_NONE;
      cnt      <= '0;
      shadow   <= 8'h00;
      addr_stb <= 1'b0;
      wr_stb   <= 1'b0;
      wr_port  <= 1'b0;
      rd_en    <= 1'b0;
      reg_addr <= 8'h00;
      wr_data  <= 8'h00;
      cfg      <= 4'hF;
    end else begin
      state    <= state_nx;
      cand     <= cand_nx;
      act      <= act_nx;
      cnt      <= cnt_nx;
      shadow   <= shadow_nx;
      addr_stb <= addr_stb_nx;
      wr_stb   <= wr_stb_nx;
      wr_port  <= wr_port_nx;
      rd_en    <= rd_en_nx;
      reg_addr <= reg_addr_nx;
      wr_data  <= wr_data_nx;
      cfg      <= cfg_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cand_nx     = cand;
    act_nx      = A_NONE;
    cnt_nx      = cnt;
    shadow_nx   = shadow;
    exit_c      = 1'b0;
    addr_stb_nx = 1'b0;
    wr_stb_nx   = 1'b0;
    wr_port_nx  = 1'b0;
    reg_addr_nx = reg_addr;
    wr_data_nx  = wr_data;
    cfg_nx      = cfg;
    cnt_inc     = (cnt >= QMAX) ? cnt : cnt + CW'(1);

    case (state)
      S_DISARM: if (mode_c == M_INACT) state_nx = S_IDLE;
      S_IDLE: begin
        if (mode_c != M_INACT) begin
          state_nx = S_QUAL;
          cand_nx  = mode_c;
          cnt_nx   = CW'(1);
        end
      end
      S_QUAL: begin
        if (mode_c == cand) begin
          cnt_nx = cnt_inc;
          if (cnt_inc >= QMAX) begin
            case (cand)
              M_LATCH: begin state_nx = S_LATCH; shadow_nx = d_s; end
              M_WRITE: begin state_nx = S_WRITE; shadow_nx = d_s; end
              M_READ:  state_nx = S_READ;
              default: state_nx = S_IDLE;
            endcase
          end
        end else begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      end
      S_LATCH: begin
        if (mode_c == M_LATCH) shadow_nx = d_s;
        else begin
          exit_c = 1'b1;
          act_nx = (shadow[7:4] == 4'hF) ? A_PORT : A_ADDR;
        end
      end
      S_WRITE: begin
        if (mode_c == M_WRITE) shadow_nx = d_s;
        else begin
          exit_c = 1'b1;
          act_nx = A_WR;
        end
      end
      S_READ: if (mode_c != M_READ) exit_c = 1'b1;
      default: state_nx = S_DISARM;
    endcase

    // A new non-idle mode on exit starts qualifying immediately.
    if (exit_c) begin
      if (mode_c != M_INACT) begin
        state_nx = S_QUAL;
        cand_nx  = mode_c;
        cnt_nx   = CW'(1);
      end else begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    end

    case (act)
      A_ADDR: begin reg_addr_nx = shadow;      addr_stb_nx = 1'b1; end
      A_PORT: begin cfg_nx      = shadow[3:0]; wr_port_nx  = 1'b1; end
      A_WR:   begin wr_data_nx  = shadow;      wr_stb_nx   = 1'b1; end
      default: ;
    endcase

    rd_en_nx = (state_nx == S_READ);
  end

endmodule

// File: doc/ay_bus_decode.md
AY_BUS_DECODE -- requirements
Module: ay_bus_decode

Interface
REQ-001 The module SHALL have the parameter QUAL_CYC, default 3, giving the number of consecutive identical synchronised bus-mode samples required to qualify a phase.
REQ-002 The module SHALL have these ports:
- clk  in  1  fclk 56 MHz; the only clock
- rst  in  1  reset; synchronous, active-high
- aybc1, aybc2, aybdir  in  1 each  AY-slot bus controls; asynchronous
- aya8, aya9_n  in  1 each  AY-slot chip selects; asynchronous
- ayd_in  in  8  AY-slot data, input side
- addr_stb  out  1  one-cycle pulse: register address latched
- wr_stb  out  1  one-cycle pulse: data write completed
- wr_port  out  1  one-cycle pulse: config-port write completed
- rd_en  out  1  level: qualified read phase is in progress
- reg_addr  out  8  last latched register address
- wr_data  out  8  last written data
- cfg  out  4  config register

Function
REQ-003 Each of the controls and selects SHALL pass through a 2-flop synchroniser, and ayd_in SHALL pass through a 2-stage register pipeline aligned with the synchronised controls.
REQ-004 The synchronised mode SHALL decode as follows:
- sel = aya8 & ~aya9_n & aybc2
- mode = INACT when sel=0
- otherwise {aybdir,aybc1}: 00 INACT, 01 READ, 10 WRITE, 11 LATCH
REQ-005 The FSM SHALL have the states DISARM, IDLE, QUAL, LATCH, WRITE and READ.
REQ-006 DISARM SHALL go to IDLE on the first cycle the mode is INACT.
REQ-007 In IDLE, a non-INACT mode SHALL move the FSM to QUAL and load the qualify counter with 1.
REQ-008 In QUAL, the counter SHALL increment while the mode equals the candidate mode; on reaching QUAL_CYC the FSM SHALL enter LATCH, WRITE or READ.
REQ-009 In QUAL, any mode change before qualification SHALL return the FSM to IDLE with no output effect (glitch rejection).
REQ-010 In LATCH and WRITE, the synchronised data SHALL be captured every cycle into a shadow register.
REQ-011 Exit from LATCH on a mode change SHALL act in the next cycle:
- shadow[7:4]==4'hF: cfg <= shadow[3:0], wr_port=1 for one cycle, reg_addr unchanged
- otherwise: reg_addr <= shadow, addr_stb=1 for one cycle
REQ-012 Exit from WRITE on a mode change SHALL set wr_data <= shadow and assert wr_stb=1 for one cycle.
REQ-013 rd_en SHALL be 1 exactly while the state is READ; exit from READ SHALL produce no strobe.
REQ-014 On any exit, if the new mode is non-INACT, the FSM SHALL enter QUAL with that mode and count 1, so back-to-back phases are handled without an idle gap.
REQ-015 At most one of addr_stb, wr_stb and wr_port SHALL be 1 in any cycle.
REQ-016 The qualify counter SHALL saturate at QUAL_CYC and SHALL never wrap.
REQ-017 Total latency from a control edge to its strobe SHALL be 2 cycles of sync plus 1 cycle of exit detect plus 1 cycle of registered output.

Reset
REQ-018 While rst=1, the outputs SHALL be: addr_stb=0, wr_stb=0, wr_port=0, rd_en=0, reg_addr=8'h00, wr_data=8'h00, cfg=4'hF.
REQ-019 While rst=1, the shadow register SHALL be 0, the counter SHALL be 0 and the state SHALL be DISARM.
REQ-020 rst asserted mid-phase SHALL suppress that phase's strobe.
REQ-021 After reset, no phase SHALL qualify until INACT has been observed, so a phase already in progress at reset release is ignored.
REQ-022 The synchroniser flops SHALL NOT be reset.

Verification
REQ-023 Directed scenarios the bench SHALL cover:
- sel=1, LATCH 10 cycles with ayd=8'h07, then INACT -> one addr_stb, reg_addr=8'h07, cfg unchanged.
- LATCH with ayd=8'hFE, then INACT -> one wr_port, cfg=4'hE, no addr_stb, reg_addr unchanged.
- WRITE 2 cycles (below QUAL_CYC) with ayd=8'h55 -> no strobe, wr_data=8'h00; then WRITE 8 cycles with ayd=8'hA5 -> one wr_stb, wr_data=8'hA5.
- LATCH 8'h0D held 6 cycles, then directly WRITE 8'h3C for 6 cycles, then INACT -> addr_stb then wr_stb, reg_addr=8'h0D, wr_data=8'h3C.
- READ 10 cycles -> rd_en=1 for the qualified span, falls within 3 cycles of the control edge, no strobes; aya9_n=1 during WRITE -> nothing.
- rst pulsed mid-WRITE with the phase still active at release -> no wr_stb until INACT is seen, then a fresh WRITE 8'h11 -> wr_stb, wr_data=8'h11.
